// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    RD_NONE  = 2'b00,
    RD_HI    = 2'b01,
    RD_LO    = 2'b10,
    RD_NONE3 = 2'b11
  } hilo_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 4;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply/divide producing the next HI/LO values.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next,
  output logic        wr_en
);

  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic        [31:0] b_safe;
  logic signed [31:0] squot;
  logic signed [31:0] srem;
  logic        [31:0] uquot;
  logic        [31:0] urem;
  logic               div_zero;
  logic               div_ovf;

  assign sa    = {{32{a[31]}}, a};
  assign sb    = {{32{b[31]}}, b};
  assign sprod = sa * sb;
  assign uprod = {32'd0, a} * {32'd0, b};

  assign div_zero = (b == '0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Dividing by 1 instead yields exactly the required results for the
  // most-negative/-1 case (q=a, r=0) and keeps the divider well-defined on /0.
  assign b_safe = (div_zero || (div_ovf && op == OP_DIV)) ? 32'd1 : b;

  assign squot = $signed(a) / $signed(b_safe);
  assign srem  = $signed(a) % $signed(b_safe);
  assign uquot = a / b_safe;
  assign urem  = a % b_safe;

  always_comb begin
    hi_next = '0;
    lo_next = '0;
    wr_en   = 1'b0;
    case (op)
      OP_MULT: begin
        hi_next = sprod[63:32];
        lo_next = sprod[31:0];
        wr_en   = 1'b1;
      end
      OP_MULTU: begin
        hi_next = uprod[63:32];
        lo_next = uprod[31:0];
        wr_en   = 1'b1;
      end
      OP_DIV: begin
        hi_next = srem;
        lo_next = squot;
        wr_en   = !div_zero;
      end
      OP_DIVU: begin
        hi_next = urem;
        lo_next = uquot;
        wr_en   = !div_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: issues mult/div, models latency, owns HI/LO, drives Busy/Stall.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        Start,
  input  logic [3:0]  MDUOP,
  input  logic [1:0]  ReadHILO,
  input  logic        Req,
  input  logic        DUseMDU,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] MDUResult
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             issue;
  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  logic             arith_wr;

  mdu_arith u_arith (
    .a       (a_q),
    .b       (b_q),
    .op      (op_q),
    .hi_next (arith_hi),
    .lo_next (arith_lo),
    .wr_en   (arith_wr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign issue = Start && !Req && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          case (MDUOP)
            OP_MULT, OP_MULTU: begin
              a_d     = SrcA;
              b_d     = SrcB;
              op_d    = MDUOP;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = SrcA;
              b_d     = SrcB;
              op_d    = MDUOP;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = SrcA;
            OP_MTLO: lo_d = SrcA;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (arith_wr) begin
            hi_d = arith_hi;
            lo_d = arith_lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy  = (state_q == RUN);
  assign Stall = DUseMDU && (Busy || (Start && !Req && is_muldiv(MDUOP)));

  always_comb begin
    case (ReadHILO)
      RD_HI:   MDUResult = hi_q;
      RD_LO:   MDUResult = lo_q;
      default: MDUResult = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Start;
  logic [3:0]  MDUOP;
  logic [1:0]  ReadHILO;
  logic        Req;
  logic        DUseMDU;
  logic        Busy;
  logic        Stall;
  logic [31:0] MDUResult;

  int unsigned n_checks;
  int unsigned n_errs;

  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Start     (Start),
    .MDUOP     (MDUOP),
    .ReadHILO  (ReadHILO),
    .Req       (Req),
    .DUseMDU   (DUseMDU),
    .Busy      (Busy),
    .Stall     (Stall),
    .MDUResult (MDUResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    ReadHILO = 2'b01;
    #1 chk({tag, "_hi"}, MDUResult, exp_hi);
    ReadHILO = 2'b10;
    #1 chk({tag, "_lo"}, MDUResult, exp_lo);
    ReadHILO = 2'b00;
  endtask

  // Drives one Start cycle at a negedge, then watches until Busy drops.
  // req_at>0 pulses Req during that RUN cycle; hold keeps Start high with new operands.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic req, input logic duse, input int req_at, input logic hold,
                        output int busy_n, output int stall_n);
    busy_n  = 0;
    stall_n = 0;
    @(negedge clk);
    MDUOP = op; SrcA = a; SrcB = b; Req = req; DUseMDU = duse; Start = 1'b1;
    #1 if (Stall) stall_n++;
    @(negedge clk);
    Req = 1'b0;
    if (hold) begin
      SrcA = 32'd9; SrcB = 32'd9;
    end else begin
      Start = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!Busy) break;
      busy_n++;
      if (Stall) stall_n++;
      Req = (req_at != 0) && (busy_n == req_at);
      @(negedge clk);
    end
    Start = 1'b0;
    Req   = 1'b0;
    #1 chk("stall_after", {31'd0, Stall}, 32'd0);
    DUseMDU = 1'b0;
  endtask

  int bn, sn;

  initial begin
    n_checks = 0;
    n_errs   = 0;
    reset = 1'b0; SrcA = '0; SrcB = '0; Start = 1'b0; MDUOP = '0;
    ReadHILO = 2'b00; Req = 1'b0; DUseMDU = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk_hilo("rst", 32'h0, 32'h0);
    reset = 1'b1;

    // DIVU 2018 / 455
    run_op(DIVU, 32'h7E2, 32'h1C7, 1'b0, 1'b0, 0, 1'b0, bn, sn);
    chk("divu_busy", bn, 10);
    chk_hilo("divu", 32'h0000_00C6, 32'h0000_0004);

    run_op(MULTU, 32'h7E2, 32'h1C7, 1'b0, 1'b0, 0, 1'b0, bn, sn);
    chk("multu_busy", bn, 5);
    chk_hilo("multu", 32'h0, 32'h000E_02AE);

    run_op(MULT, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, 0, 1'b0, bn, sn);
    chk("mult_busy", bn, 5);
    chk_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    run_op(DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0, 0, 1'b0, bn, sn);
    chk_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0, bn, sn);
    chk_hilo("div_ovf", 32'h0, 32'h8000_0000);

    run_op(MTHI, 32'h11, 32'h0, 1'b0, 1'b0, 0, 1'b0, bn, sn);
    chk("mthi_busy", bn, 0);
    run_op(MTLO, 32'h22, 32'h0, 1'b0, 1'b0, 0, 1'b0, bn, sn);
    chk_hilo("mt", 32'h11, 32'h22);

    run_op(DIVU, 32'h5, 32'h0, 1'b0, 1'b0, 0, 1'b0, bn, sn);
    chk("div0_busy", bn, 10);
    chk_hilo("div0", 32'h11, 32'h22);

    // Req in the issue cycle suppresses everything
    run_op(DIV, 32'd100, 32'd7, 1'b1, 1'b0, 0, 1'b0, bn, sn);
    chk("req_busy", bn, 0);
    chk_hilo("req_sup", 32'h11, 32'h22);
    run_op(MTHI, 32'h99, 32'h0, 1'b1, 1'b0, 0, 1'b0, bn, sn);
    chk_hilo("req_mthi", 32'h11, 32'h22);

    run_op(DIV, 32'd100, 32'd7, 1'b0, 1'b0, 3, 1'b0, bn, sn);
    chk("req_run_busy", bn, 10);
    chk_hilo("req_run", 32'h2, 32'hE);

    // Stall coverage
    run_op(MULT, 32'd3, 32'd4, 1'b0, 1'b1, 0, 1'b0, bn, sn);
    chk("stall_busy", bn, 5);
    chk("stall_cycles", sn, 6);
    chk_hilo("mult34", 32'h0, 32'hC);

    run_op(MULTU, 32'd3, 32'd5, 1'b0, 1'b0, 0, 1'b0, bn, sn);
    chk("nostall_cycles", sn, 0);

    run_op(MULT, 32'd6, 32'd7, 1'b0, 1'b1, 0, 1'b1, bn, sn);
    chk("hold_busy", bn, 5);
    chk_hilo("hold", 32'h0, 32'd42);

    // Async reset in the middle of a divide
    @(negedge clk);
    MDUOP = DIV; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
    reset = 1'b0;
    #1 chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk_hilo("arst", 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    MDUOP = MTLO; SrcA = 32'h5; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    #1 chk("mtlo_busy", {31'd0, Busy}, 32'd0);
    chk_hilo("mtlo5", 32'h0, 32'h5);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle sequencer and HI/LO owner for the multiply/divide unit in the E stage of the pipelined MIPS core.
- Accepts MDUOP/Start from E and latches the operands.
- Models the fixed mult/div latency with a down-counter and drives Busy.
- Generates the D-stage stall for MDU-dependent instructions.
- Commits results into HI/LO and masks issue on an interrupt/exception request (Req).
- Arithmetic is delegated to a combinational sub-module.

Parameters:
MULT_CYCLES, 5, Busy cycles for MULT/MULTU (legal range 1..15).
DIV_CYCLES, 10, Busy cycles for DIV/DIVU (legal range 1..15).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
SrcA  in  32  rs operand (E stage)
SrcB  in  32  rt operand (E stage)
Start  in  1  E-stage instruction is an MDU op this cycle
MDUOP  in  4  0000 NOP, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO, others NOP
ReadHILO  in  2  00 none, 01 HI, 10 LO, 11 none
Req  in  1  exception/interrupt flush of the E-stage instruction
DUseMDU  in  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo
Busy  out  1  mult/div in progress
Stall  out  1  hold D stage
MDUResult  out  32  mfhi/mflo read data

Behaviour:
Reset (reset=0, async):
- state=IDLE, cnt=0, HI=LO=0, latched operands and op cleared.
- Busy=0, Stall=0, MDUResult=0.

FSM states: IDLE, RUN. Define issue = Start && !Req && state==IDLE.

IDLE:
- issue with MULT/MULTU/DIV/DIVU: latch SrcA, SrcB and op; cnt <= MULT_CYCLES or DIV_CYCLES; go to RUN.
- issue with MTHI: HI <= SrcA at the next edge. MTLO: LO <= SrcA at the next edge. Stay in IDLE, Busy stays 0.
- Start with NOP/undefined op: no effect.

RUN:
- cnt decrements every cycle.
- When cnt==1: HI/LO <= arithmetic result at that edge; go to IDLE.
- Start is ignored in RUN. The pipeline guarantees Stall prevents it; the bench flags it.

Timing: issue at edge t gives Busy=1 for exactly N cycles (t+1..t+N). HI/LO update at the edge ending cycle t+N. Busy=0 and the new HI/LO are visible from cycle t+N+1.

Req:
- Req=1 in the issue cycle suppresses issue for all ops, including MTHI/MTLO; no state change.
- Req while in RUN does not abort. The op was architecturally committed, so it completes normally.

Busy: registered, equals (state==RUN).

Stall: DUseMDU && (Busy || (Start && !Req && MDUOP in {MULT,MULTU,DIV,DIVU})). Combinational.

MDUResult: combinational mux of HI/LO on ReadHILO. Reads during RUN return the old value (Stall prevents this in practice).

Arithmetic rules (in mdu_arith, 32x32):
- MULT: signed 64-bit product; HI = [63:32], LO = [31:0].
- MULTU: unsigned product, same split.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divisor == 0: HI and LO are left unchanged. The op still takes DIV_CYCLES and Busy behaves normally.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.

Reset mid-RUN: immediate return to the reset values; the in-flight result is discarded.

Decomposition:
Shared package (mdu_pkg):
- MDUOP encodings.
- ReadHILO encodings.
- State enum {IDLE, RUN}.
- Default latency constants.

Sub-module mdu_arith:
- Purely combinational.
- Inputs: latched A, B, op. Outputs: hi_next, lo_next, wr_en (wr_en=0 on divide-by-zero).

mdu_ctrl contains the FSM, counter, operand latches, HI/LO registers and the Stall/Busy/readout logic.

Test Plan:
1. Release reset; DIVU SrcA=0x7E2, SrcB=0x1C7, Start for 1 cycle -> Busy high exactly 10 cycles; then HI=0x000000C6, LO=0x00000004; MDUResult=0xC6 with ReadHILO=01.
2. MULTU 0x7E2 x 0x1C7 -> Busy 5 cycles; LO=0x000E02AE, HI=0. MULT 0xFFFFFFFF x 0x2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
3. DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU x/0 after MTHI 0x11, MTLO 0x22 -> Busy 10 cycles, HI=0x11, LO=0x22 unchanged.
4. DIV with Req=1 in the Start cycle -> Busy stays 0, HI/LO unchanged. Req pulse at RUN cycle 3 -> op completes on schedule with the correct result.
5. DUseMDU=1 during MULT issue and RUN -> Stall=1 from the issue cycle through the last Busy cycle, 0 afterwards. DUseMDU=0 -> Stall=0 throughout. Start held while Busy -> no relatch; result matches the first op.
6. Assert reset at RUN cycle 4 of a DIV -> Busy, HI, LO and MDUResult go to 0 immediately, without waiting for a clock edge. After release, a new MTLO 0x5 -> LO=0x5 next cycle with Busy=0.
